// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command path: header field widths, opcode
// values and the one-hot state encoding of the command engine.
package spi_pkg;

  localparam int HDR_WL  = 6;  // header width {op[1:0], addr[3:0]}
  localparam int ADDR_WL = 4;  // register address width

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [6:0] {
    ST_IDLE     = 7'b0000001,
    ST_WR_DATA  = 7'b0000010,
    ST_WR_ISSUE = 7'b0000100,
    ST_RD_REQ   = 7'b0001000,
    ST_RD_LOAD  = 7'b0010000,
    ST_RD_DATA  = 7'b0100000,
    ST_DONE     = 7'b1000000
  } state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// Shift register with parallel load, MSB-first serial out.
// Ports:
//   iCLK, iRSTn  clock, synchronous active-low reset
//   iCLR         synchronous clear (frame end)
//   iEN          shift strobe: sr <= {sr[WL-2:0], iSI}
//   iLOAD        parallel load from iDATA (priority over iEN)
//   iDATA        parallel load value
//   iSI          serial in
//   oDATA        parallel contents
//   oSO          serial out (MSB)
module spi_shift_reg #(
  parameter int WL = 16
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iCLR,
  input  logic          iEN,
  input  logic          iLOAD,
  input  logic [WL-1:0] iDATA,
  input  logic          iSI,
  output logic [WL-1:0] oDATA,
  output logic          oSO
);

  logic [WL-1:0] sr;

  always_ff @(posedge iCLK) begin
    if (!iRSTn)      sr <= '0;
    else if (iCLR)   sr <= '0;
    else if (iLOAD)  sr <= iDATA;
    else if (iEN)    sr <= {sr[WL-2:0], iSI};
  end

  assign oDATA = sr;
  assign oSO   = sr[WL-1];

endmodule

// File: rtl/spi_cmd_engine.sv
// SPI command engine: consumes the decoded 6-bit header and runs one write or
// read transaction per chip-select frame.
// Ports:
//   iCLK, iRSTn         clock, synchronous active-low reset
//   iCLR                frame end; synchronous abort to IDLE
//   iEN, MOSI           SPI bit strobe and serial data in
//   iHEADER, iHEADER_EN decoded header and its completion pulse
//   iRD_DATA            register read data, valid 1 cycle after oRD_REQ
//   oRD_REQ, oRD_ADDR   read request pulse and address
//   oWR_EN, oWR_ADDR,
//   oWR_DATA            write strobe, address and data
//   oMISO               serial data out (MSB first)
//   oBUSY               not IDLE
//   oERR                sticky reserved-opcode flag
module spi_cmd_engine
  import spi_pkg::*;
#(
  parameter int DATA_WL = 16,
  parameter int CNT_WL  = 5
) (
  input  logic               iCLK,
  input  logic               iRSTn,
  input  logic               iCLR,
  input  logic               iEN,
  input  logic               MOSI,
  input  logic [HDR_WL-1:0]  iHEADER,
  input  logic               iHEADER_EN,
  input  logic [DATA_WL-1:0] iRD_DATA,
  output logic               oRD_REQ,
  output logic [ADDR_WL-1:0] oRD_ADDR,
  output logic               oWR_EN,
  output logic [ADDR_WL-1:0] oWR_ADDR,
  output logic [DATA_WL-1:0] oWR_DATA,
  output logic               oMISO,
  output logic               oBUSY,
  output logic               oERR
);

  state_t               state, state_next;
  logic                 hdr_pend;
  logic [ADDR_WL-1:0]   addr;
  logic [CNT_WL-1:0]    cnt;
  logic                 err;
  logic [DATA_WL-1:0]   rx_data;
  logic                 rx_so_unused;
  logic [DATA_WL-1:0]   tx_data_unused;
  logic                 tx_so;
  logic [1:0]           op;
  logic                 last_bit;

  assign op       = iHEADER[HDR_WL-1 -: 2];
  assign last_bit = (cnt == CNT_WL'(DATA_WL - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge iCLK) begin
    if (!iRSTn)     state <= ST_IDLE;
    else if (iCLR)  state <= ST_IDLE;
    else            state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_next unassigned and infers a latch.
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (hdr_pend) begin
          case (op)
            OP_WR:   state_next = ST_WR_DATA;
            OP_RD:   state_next = ST_RD_REQ;
            default: state_next = ST_DONE;  // NOP and reserved
          endcase
        end
      end
      ST_WR_DATA:  if (iEN && last_bit) state_next = ST_WR_ISSUE;
      ST_WR_ISSUE: state_next = ST_DONE;
      ST_RD_REQ:   state_next = ST_RD_LOAD;
      ST_RD_LOAD:  state_next = ST_RD_DATA;
      ST_RD_DATA:  if (iEN && last_bit) state_next = ST_DONE;
      ST_DONE:     state_next = ST_DONE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Header pending flag, address latch, bit counter and error flag.
  // iHEADER_EN coincides with the last header shift, so the header is
  // sampled one cycle later through hdr_pend.
  always_ff @(posedge iCLK) begin
    if (!iRSTn || iCLR) begin
      hdr_pend <= 1'b0;
      addr     <= '0;
      cnt      <= '0;
      err      <= 1'b0;
    end else begin
      hdr_pend <= iHEADER_EN;
      if (state == ST_IDLE && hdr_pend) begin
        addr <= iHEADER[ADDR_WL-1:0];
        if (op == OP_RSV) err <= 1'b1;
      end
      // The counter restarts on every state change so each payload phase
      // begins at zero.
      if (state_next != state)
        cnt <= '0;
      else if (iEN && (state == ST_WR_DATA || state == ST_RD_DATA))
        cnt <= cnt + 1'b1;
    end
  end

  spi_shift_reg #(.WL(DATA_WL)) u_rx (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .iCLR  (iCLR),
    .iEN   (iEN && (state == ST_WR_DATA)),
    .iLOAD (1'b0),
    .iDATA ('0),
    .iSI   (MOSI),
    .oDATA (rx_data),
    .oSO   (rx_so_unused)
  );

  spi_shift_reg #(.WL(DATA_WL)) u_tx (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .iCLR  (iCLR),
    .iEN   (iEN && (state == ST_RD_DATA)),
    .iLOAD (state == ST_RD_LOAD),
    .iDATA (iRD_DATA),
    .iSI   (1'b0),
    .oDATA (tx_data_unused),
    .oSO   (tx_so)
  );

  // Outputs. Strobes are masked by reset and iCLR so an abort in the same
  // cycle never lets a request or write escape.
  always_comb begin
    oBUSY    = (state != ST_IDLE);
    oWR_EN   = (state == ST_WR_ISSUE) && iRSTn && !iCLR;
    oRD_REQ  = (state == ST_RD_REQ) && iRSTn && !iCLR;
    oMISO    = (state == ST_RD_DATA) ? tx_so : 1'b0;
    oWR_ADDR = addr;
    oRD_ADDR = addr;
    oWR_DATA = rx_data;
    oERR     = err;
  end

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Directed self-checking bench for spi_cmd_engine.
module tb_spi_cmd_engine;

  logic        iCLK = 1'b0;
  logic        iRSTn, iCLR, iEN, MOSI, iHEADER_EN;
  logic [5:0]  iHEADER;
  logic [15:0] iRD_DATA;
  logic        oRD_REQ, oWR_EN, oMISO, oBUSY, oERR;
  logic [3:0]  oRD_ADDR, oWR_ADDR;
  logic [15:0] oWR_DATA;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  logic [15:0] rd_word = 16'h0000;
  logic [15:0] word;

  always #5 iCLK = ~iCLK;

  spi_cmd_engine #(.DATA_WL(16), .CNT_WL(5)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(iCLR), .iEN(iEN), .MOSI(MOSI),
    .iHEADER(iHEADER), .iHEADER_EN(iHEADER_EN), .iRD_DATA(iRD_DATA),
    .oRD_REQ(oRD_REQ), .oRD_ADDR(oRD_ADDR), .oWR_EN(oWR_EN),
    .oWR_ADDR(oWR_ADDR), .oWR_DATA(oWR_DATA), .oMISO(oMISO),
    .oBUSY(oBUSY), .oERR(oERR)
  );

  // Register file model: data appears exactly one cycle after the request.
  always @(posedge iCLK) iRD_DATA <= oRD_REQ ? rd_word : 16'h0000;

  // Strobe counters sampled away from the active edge.
  always @(negedge iCLK) begin
    if (oWR_EN)  wr_cnt++;
    if (oRD_REQ) rd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  // One SPI bit: iEN high for exactly one cycle; returns one cycle later.
  task automatic strobe(input logic b);
    @(negedge iCLK);
    iEN = 1'b1; MOSI = b;
    @(negedge iCLK);
    iEN = 1'b0; MOSI = 1'b0;
  endtask

  // Header pulse; returns once the engine has left IDLE.
  task automatic header(input logic [1:0] op, input logic [3:0] a);
    @(negedge iCLK);
    iHEADER = {op, a}; iHEADER_EN = 1'b1;
    @(negedge iCLK);
    iHEADER_EN = 1'b0;
    @(negedge iCLK);
  endtask

  task automatic frame_end();
    @(negedge iCLK);
    iCLR = 1'b1;
    @(negedge iCLK);
    iCLR = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      strobe(w[i]);
      if (i > 0) idle(2);
    end
  endtask

  initial begin
    iRSTn = 1'b0; iCLR = 1'b0; iEN = 1'b0; MOSI = 1'b0;
    iHEADER = 6'h00; iHEADER_EN = 1'b0;
    idle(3);
    check("rst_busy", oBUSY, 0);
    check("rst_wr_en", oWR_EN, 0);
    check("rst_rd_req", oRD_REQ, 0);
    check("rst_miso", oMISO, 0);
    check("rst_err", oERR, 0);
    check("rst_wr_data", oWR_DATA, 0);
    iRSTn = 1'b1;
    idle(2);

    // 1: WRITE addr 3, data 0xA5C3
    header(2'b01, 4'd3);
    check("wr1_busy", oBUSY, 1);
    send_word(16'hA5C3);
    check("wr1_en", oWR_EN, 1);
    check("wr1_addr", oWR_ADDR, 3);
    check("wr1_data", oWR_DATA, 16'hA5C3);
    @(negedge iCLK);
    check("wr1_single", oWR_EN, 0);
    check("wr1_done_busy", oBUSY, 1);
    frame_end();
    check("wr1_idle", oBUSY, 0);
    check("wr1_count", wr_cnt, 1);

    // 2: READ addr 7, register value 0x1234
    rd_word = 16'h1234;
    header(2'b10, 4'd7);
    check("rd2_req", oRD_REQ, 1);
    check("rd2_addr", oRD_ADDR, 7);
    check("rd2_miso_req", oMISO, 0);
    idle(2);
    word = 16'h1234;
    for (int i = 15; i >= 0; i--) begin
      check($sformatf("rd2_bit%0d", i), oMISO, word[i]);
      strobe(1'b0);
      idle(2);
    end
    check("rd2_done_miso", oMISO, 0);
    check("rd2_addr_held", oRD_ADDR, 7);
    check("rd2_count", rd_cnt, 1);
    frame_end();
    check("rd2_idle", oBUSY, 0);

    // 3: abort a WRITE after 8 bits, then a normal frame
    header(2'b01, 4'd5);
    for (int i = 0; i < 8; i++) begin strobe(1'b1); idle(2); end
    check("ab3_busy", oBUSY, 1);
    frame_end();
    check("ab3_idle", oBUSY, 0);
    idle(2);
    check("ab3_no_wr", wr_cnt, 1);
    header(2'b01, 4'd9);
    send_word(16'h0F0F);
    check("ab3_next_en", oWR_EN, 1);
    check("ab3_next_addr", oWR_ADDR, 9);
    check("ab3_next_data", oWR_DATA, 16'h0F0F);
    frame_end();
    idle(1);
    check("ab3_count", wr_cnt, 2);

    // NOP: goes busy, no error, no strobes
    header(2'b00, 4'd1);
    check("nop_busy", oBUSY, 1);
    check("nop_err", oERR, 0);
    frame_end();

    // 4: reserved opcode
    header(2'b11, 4'd2);
    check("rsv4_err", oERR, 1);
    check("rsv4_busy", oBUSY, 1);
    for (int i = 0; i < 4; i++) begin
      strobe(1'b1);
      check("rsv4_miso", oMISO, 0);
      idle(2);
    end
    check("rsv4_err_sticky", oERR, 1);
    frame_end();
    check("rsv4_err_clr", oERR, 0);
    idle(1);
    check("rsv4_no_wr", wr_cnt, 2);
    check("rsv4_no_rd", rd_cnt, 1);

    // 5: reset in the middle of a read (after 9 bits)
    rd_word = 16'hBEEF;
    header(2'b10, 4'd2);
    idle(2);
    for (int i = 0; i < 9; i++) begin strobe(1'b0); idle(2); end
    check("rs5_busy_before", oBUSY, 1);
    @(negedge iCLK);
    iRSTn = 1'b0;
    @(negedge iCLK);
    check("rs5_busy", oBUSY, 0);
    check("rs5_miso", oMISO, 0);
    check("rs5_rd_addr", oRD_ADDR, 0);
    check("rs5_wr_data", oWR_DATA, 0);
    check("rs5_rd_req", oRD_REQ, 0);
    iRSTn = 1'b1;
    idle(3);
    check("rs5_rd_count", rd_cnt, 2);
    check("rs5_wr_count", wr_cnt, 2);

    // 6a: 20 extra bits after a completed WRITE
    header(2'b01, 4'd1);
    send_word(16'h8001);
    check("ex6_en", oWR_EN, 1);
    check("ex6_data", oWR_DATA, 16'h8001);
    for (int i = 0; i < 20; i++) begin idle(2); strobe(1'b1); end
    idle(1);
    check("ex6_single", wr_cnt, 3);
    frame_end();

    // 6b: iCLR together with the final payload bit
    header(2'b01, 4'd4);
    for (int i = 0; i < 15; i++) begin strobe(1'b1); idle(2); end
    @(negedge iCLK);
    iEN = 1'b1; MOSI = 1'b1; iCLR = 1'b1;
    @(negedge iCLK);
    iEN = 1'b0; MOSI = 1'b0; iCLR = 1'b0;
    check("cl6_no_en", oWR_EN, 0);
    check("cl6_idle", oBUSY, 0);
    idle(3);
    check("cl6_count", wr_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
